// File: rtl/p5_writeback_if.sv
// Bundle between the memory stage / decode and the write-back stage.
// The master side drives the memory-stage beat and the decode read addresses.
interface p5_writeback_if;
  logic        validp4;
  logic        WriteRegp4;
  logic [2:0]  RegAddressp4;
  logic [15:0] readOutData;
  logic [15:0] aluResultp4;
  logic        memToRegp4;
  logic        outEnp4;
  logic        haltp4;
  logic [2:0]  readAddr1;
  logic [2:0]  readAddr2;
  logic [15:0] readData1;
  logic [15:0] readData2;
  logic [15:0] outPort;
  logic        outValid;
  logic        halted;
  logic [15:0] retireCount;

  modport master (
    output validp4, WriteRegp4, RegAddressp4, readOutData, aluResultp4,
           memToRegp4, outEnp4, haltp4, readAddr1, readAddr2,
    input  readData1, readData2, outPort, outValid, halted, retireCount
  );

  modport slave (
    input  validp4, WriteRegp4, RegAddressp4, readOutData, aluResultp4,
           memToRegp4, outEnp4, haltp4, readAddr1, readAddr2,
    output readData1, readData2, outPort, outValid, halted, retireCount
  );
endinterface

// File: rtl/p5_writeback.sv
// Write-back stage of the SIMPLE 16-bit pipeline: register file with bypassed
// read ports, OUT port register, sticky halt latch and retired-instruction counter.
module p5_writeback (
  input logic           clock,
  input logic           reset,
  p5_writeback_if.slave wb
);

  logic [15:0] regFile [8];
  logic [15:0] wbData;
  logic [15:0] outPortQ;
  logic        outValidQ;
  logic        haltedQ;
  logic [15:0] retireCountQ;
  logic        live;
  logic        liveWrite;

  // Once halted, every later beat is treated as a bubble.
  assign live      = wb.validp4 && !haltedQ;
  assign liveWrite = live && wb.WriteRegp4;
  assign wbData    = wb.memToRegp4 ? wb.readOutData : wb.aluResultp4;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regFile[i] <= 16'h0000;
      end
      outPortQ     <= 16'h0000;
      outValidQ    <= 1'b0;
      haltedQ      <= 1'b0;
      retireCountQ <= 16'h0000;
    end else begin
      outValidQ <= live && wb.outEnp4;
      if (liveWrite) begin
        regFile[wb.RegAddressp4] <= wbData;
      end
      if (live && wb.outEnp4) begin
        outPortQ <= wb.aluResultp4;
      end
      if (live) begin
        retireCountQ <= retireCountQ + 16'd1;
      end
      if (live && wb.haltp4) begin
        haltedQ <= 1'b1;
      end
    end
  end

  // Same-cycle bypass so decode sees the value being committed this cycle.
  always_comb begin
    wb.readData1 = regFile[wb.readAddr1];
    wb.readData2 = regFile[wb.readAddr2];
    if (liveWrite && (wb.RegAddressp4 == wb.readAddr1)) begin
      wb.readData1 = wbData;
    end
    if (liveWrite && (wb.RegAddressp4 == wb.readAddr2)) begin
      wb.readData2 = wbData;
    end
  end

  assign wb.outPort     = outPortQ;
  assign wb.outValid    = outValidQ;
  assign wb.halted      = haltedQ;
  assign wb.retireCount = retireCountQ;

endmodule

// File: tb/tb_p5_writeback.sv
// Scenario bench for p5_writeback: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_p5_writeback;

  typedef struct {
    string       name;
    logic [15:0] value;
  } expT;

  logic clock;
  logic reset;
  int   checkCount;
  int   passCount;
  expT  expQ[$];

  p5_writeback_if wbIf ();

  p5_writeback dut (
    .clock (clock),
    .reset (reset),
    .wb    (wbIf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic wr, input logic [2:0] addr,
                               input logic [15:0] mem, input logic [15:0] alu,
                               input logic m2r, input logic outEn, input logic halt);
    wbIf.validp4      = valid;
    wbIf.WriteRegp4   = wr;
    wbIf.RegAddressp4 = addr;
    wbIf.readOutData  = mem;
    wbIf.aluResultp4  = alu;
    wbIf.memToRegp4   = m2r;
    wbIf.outEnp4      = outEn;
    wbIf.haltp4       = halt;
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    expT e;
    bubble();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wbIf.readAddr1 = 3'(i);
      wbIf.readAddr2 = 3'(7 - i);
      expQ.push_back('{name: "resetRd1", value: 16'h0000});
      expQ.push_back('{name: "resetRd2", value: 16'h0000});
      #3;
      e = expQ.pop_front();
      checkCount++;
      if (wbIf.readData1 !== e.value) $display("[TB] FAIL %s r%0d got %h want %h", e.name, i, wbIf.readData1, e.value);
      else passCount++;
      e = expQ.pop_front();
      checkCount++;
      if (wbIf.readData2 !== e.value) $display("[TB] FAIL %s r%0d got %h want %h", e.name, 7 - i, wbIf.readData2, e.value);
      else passCount++;
    end
    expQ.push_back('{name: "resetHalted", value: 16'h0000});
    expQ.push_back('{name: "resetRetire", value: 16'h0000});
    expQ.push_back('{name: "resetOutValid", value: 16'h0000});
    e = expQ.pop_front();
    checkCount++;
    if ({15'd0, wbIf.halted} !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.halted, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.retireCount !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.retireCount, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if ({15'd0, wbIf.outValid} !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.outValid, e.value);
    else passCount++;
  endtask

  task automatic test_write_load();
    expT e;
    wbIf.readAddr1 = 3'd3;
    applyStimulus(1'b1, 1'b1, 3'd3, 16'h9999, 16'h1234, 1'b0, 1'b0, 1'b0);
    expQ.push_back('{name: "aluWriteR3", value: 16'h1234});
    step();
    bubble();
    #3;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData1 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData1, e.value);
    else passCount++;
    step();
    applyStimulus(1'b1, 1'b1, 3'd3, 16'hBEEF, 16'h5555, 1'b1, 1'b0, 1'b0);
    expQ.push_back('{name: "loadWriteR3", value: 16'hBEEF});
    expQ.push_back('{name: "retireAfterTwo", value: 16'd2});
    step();
    bubble();
    #3;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData1 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData1, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.retireCount !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.retireCount, e.value);
    else passCount++;
  endtask

  task automatic test_bypass();
    expT e;
    step();
    wbIf.readAddr1 = 3'd5;
    wbIf.readAddr2 = 3'd5;
    applyStimulus(1'b1, 1'b1, 3'd5, 16'h0000, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    expQ.push_back('{name: "bypassRd1", value: 16'hA5A5});
    expQ.push_back('{name: "bypassRd2", value: 16'hA5A5});
    #3;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData1 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData1, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData2 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData2, e.value);
    else passCount++;
    step();
    applyStimulus(1'b0, 1'b1, 3'd5, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    expQ.push_back('{name: "bubbleNoBypass", value: 16'hA5A5});
    expQ.push_back('{name: "bubbleNoWrite", value: 16'hA5A5});
    #3;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData1 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData1, e.value);
    else passCount++;
    step();
    bubble();
    #3;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData2 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData2, e.value);
    else passCount++;
  endtask

  task automatic test_out();
    expT e;
    step();
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0000, 16'h00C3, 1'b0, 1'b1, 1'b0);
    expQ.push_back('{name: "outValidPulse", value: 16'd1});
    expQ.push_back('{name: "outPortSet", value: 16'h00C3});
    expQ.push_back('{name: "outValidDrop", value: 16'd0});
    expQ.push_back('{name: "outPortHeld", value: 16'h00C3});
    step();
    bubble();
    e = expQ.pop_front();
    checkCount++;
    if ({15'd0, wbIf.outValid} !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.outValid, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.outPort !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.outPort, e.value);
    else passCount++;
    step();
    e = expQ.pop_front();
    checkCount++;
    if ({15'd0, wbIf.outValid} !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.outValid, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.outPort !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.outPort, e.value);
    else passCount++;
  endtask

  task automatic test_halt();
    expT e;
    logic [15:0] retireBefore;
    retireBefore = 16'd4;
    wbIf.readAddr1 = 3'd1;
    applyStimulus(1'b1, 1'b1, 3'd1, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, 1'b1, 3'd1, 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0);
    expQ.push_back('{name: "haltedNoBypass", value: 16'h0001});
    #3;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData1 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData1, e.value);
    else passCount++;
    expQ.push_back('{name: "haltedR1", value: 16'h0001});
    expQ.push_back('{name: "haltedSet", value: 16'd1});
    expQ.push_back('{name: "haltRetireOnce", value: retireBefore + 16'd1});
    expQ.push_back('{name: "haltNoOut", value: 16'd0});
    step();
    bubble();
    #3;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData1 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData1, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if ({15'd0, wbIf.halted} !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.halted, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.retireCount !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.retireCount, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if ({15'd0, wbIf.outValid} !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.outValid, e.value);
    else passCount++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    expQ.push_back('{name: "resetClearsHalt", value: 16'd0});
    expQ.push_back('{name: "resetClearsR1", value: 16'h0000});
    #3;
    e = expQ.pop_front();
    checkCount++;
    if ({15'd0, wbIf.halted} !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.halted, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData1 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData1, e.value);
    else passCount++;
  endtask

  task automatic test_wrap_and_reset();
    expT e;
    step();
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) begin
      step();
    end
    bubble();
    expQ.push_back('{name: "retireMax", value: 16'hFFFF});
    #3;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.retireCount !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.retireCount, e.value);
    else passCount++;
    step();
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    expQ.push_back('{name: "retireWrap", value: 16'h0000});
    step();
    bubble();
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.retireCount !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.retireCount, e.value);
    else passCount++;
    wbIf.readAddr1 = 3'd2;
    wbIf.readAddr2 = 3'd4;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 3'd2, 16'h0000, 16'h7777, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 3'd4, 16'h4444, 16'h0000, 1'b1, 1'b0, 1'b0);
    expQ.push_back('{name: "resetDiscardsR2", value: 16'h0000});
    expQ.push_back('{name: "postResetWriteR4", value: 16'h4444});
    expQ.push_back('{name: "postResetRetire", value: 16'd1});
    #3;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData1 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData1, e.value);
    else passCount++;
    step();
    bubble();
    #3;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.readData2 !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.readData2, e.value);
    else passCount++;
    e = expQ.pop_front();
    checkCount++;
    if (wbIf.retireCount !== e.value) $display("[TB] FAIL %s got %h want %h", e.name, wbIf.retireCount, e.value);
    else passCount++;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    wbIf.readAddr1 = 3'd0;
    wbIf.readAddr2 = 3'd0;
    bubble();
    $display("[TB] starting p5_writeback bench");
    test_reset();
    test_write_load();
    test_bypass();
    test_out();
    test_halt();
    test_wrap_and_reset();
    checkCount++;
    if (expQ.size() !== 0) $display("[TB] FAIL scoreboardEmpty got %0d want 0", expQ.size());
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/p5_writeback.md
# p5_writeback

Final stage of the SIMPLE 16-bit pipeline, directly downstream of the memory stage. It selects write-back data (memory load data or forwarded ALU result), commits it to the 8 x 16-bit general register file, and serves two same-cycle-bypassed read ports to decode. It also owns the OUT port register, the sticky halt latch and the retired-instruction counter.

## Interface
- No parameters; data width fixed at 16, register count fixed at 8.
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- validp4  in  1  beat from memory stage carries a real instruction (0 = bubble)
- WriteRegp4  in  1  instruction writes a register
- RegAddressp4  in  3  destination register number
- readOutData  in  16  load data from memory stage
- aluResultp4  in  16  ALU result delayed to align with readOutData
- memToRegp4  in  1  1 = write readOutData, 0 = write aluResultp4
- outEnp4  in  1  instruction is OUT
- haltp4  in  1  instruction is HLT
- readAddr1, readAddr2  in  3 each  decode read addresses
- readData1, readData2  out  16 each  register contents (combinational, bypassed)
- outPort  out  16  last value written by OUT
- outValid  out  1  one-cycle pulse when outPort updates
- halted  out  1  sticky halt status
- retireCount  out  16  count of retired instructions

## Operation
- wbData = memToRegp4 ? readOutData : aluResultp4 (combinational).
- Beat is live when validp4 = 1 and halted = 0; non-live beats have no effect on any state.
- Live beat with WriteRegp4 = 1: regfile[RegAddressp4] <= wbData at rising edge. All 8 registers writable (no hardwired zero).
- Read ports: readDataN = wbData if live and WriteRegp4 and RegAddressp4 == readAddrN, else regfile[readAddrN]. Both ports bypass independently; same address on both ports returns the same value.
- Live beat with outEnp4 = 1: outPort <= aluResultp4, outValid = 1 for the following cycle only; otherwise outValid = 0 and outPort holds.
- Live beat: retireCount <= retireCount + 1, modulo 2^16 (0xFFFF wraps to 0x0000, no flag).
- Live beat with haltp4 = 1: halted <= 1. The halt beat itself retires (counted, its write/OUT performed). halted stays 1 until reset; all later beats ignored.
- Reset: all 8 registers, outPort, retireCount = 0x0000; outValid = 0; halted = 0. Reset wins over any simultaneous live beat (no write, no count).

## Timing
- Write latency: data on inputs in cycle N visible in regfile from cycle N+1; visible on read ports in cycle N itself via bypass.
- outValid, outPort, halted, retireCount are registered; change one cycle after the causing beat.
- No backpressure: stage accepts one beat every cycle, never stalls upstream.
- Read ports purely combinational from readAddrN, inputs and regfile state; no clock-edge dependence.
- Reset mid-stream: beat present in reset cycle discarded; first beat after reset deasserts is processed normally.

## Test plan
- Reset then read all 8 registers -> all read 0x0000; halted = 0, retireCount = 0, outValid = 0.
- Live write R3 <= ALU 0x1234 (memToReg = 0), then live load R3 <= mem 0xBEEF (memToReg = 1) -> readData1(R3) = 0x1234 then 0xBEEF; retireCount = 2.
- Same-cycle bypass: live write R5 <= 0xA5A5 with readAddr1 = readAddr2 = 5 -> both ports 0xA5A5 that cycle; bubble (validp4 = 0) writing R5 <= 0xFFFF -> R5 still 0xA5A5.
- OUT beat with aluResultp4 = 0x00C3 -> next cycle outPort = 0x00C3, outValid = 1 for exactly one cycle, then 0 with outPort held.
- HLT beat also writing R1 <= 0x0001, followed by live write R1 <= 0x0002 -> R1 = 0x0001, halted = 1, retireCount increments once only; reset clears halted.
- Preload retireCount to 0xFFFF via 65535 live beats, one more -> 0x0000; reset asserted with a live write R2 <= 0x7777 -> R2 = 0x0000.
